// File: rtl/bus_pkg.sv
// Shared types and constants for the fetch/data memory bus arbiter.
package bus_pkg;

  localparam int unsigned BUS_W  = 32;
  localparam int unsigned STRB_W = BUS_W / 8;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    DATA  = 2'b10
  } state_t;

  typedef enum logic {
    GRANT_FETCH = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_t;

endpackage

// File: rtl/bus_lane_align.sv
// Byte-lane steering for stores and extraction/extension for loads.
module bus_lane_align
  import bus_pkg::*;
(
  input  logic [1:0]        i_st_size,
  input  logic [1:0]        i_st_addr_lo,
  input  logic [BUS_W-1:0]  i_st_data,
  output logic [BUS_W-1:0]  o_st_data_c,
  output logic [STRB_W-1:0] o_st_strobe_c,
  input  logic [1:0]        i_ld_size,
  input  logic [1:0]        i_ld_addr_lo,
  input  logic              i_ld_signed,
  input  logic [BUS_W-1:0]  i_rd_data,
  output logic [BUS_W-1:0]  o_ld_data_c
);

  logic [4:0]       w_shamt;
  logic [BUS_W-1:0] w_shifted;

  // Replicate the right-aligned store data across every lane it may land in.
  always_comb begin
    o_st_data_c   = i_st_data;
    o_st_strobe_c = 4'b1111;
    case (i_st_size)
      SIZE_BYTE: begin
        o_st_data_c   = {4{i_st_data[7:0]}};
        o_st_strobe_c = 4'b0001 << i_st_addr_lo;
      end
      SIZE_HALF: begin
        o_st_data_c   = {2{i_st_data[15:0]}};
        o_st_strobe_c = 4'b0011 << {i_st_addr_lo[1], 1'b0};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_shamt = 5'd0;
    case (i_ld_size)
      SIZE_BYTE: w_shamt = {i_ld_addr_lo, 3'b000};
      SIZE_HALF: w_shamt = {i_ld_addr_lo[1], 4'b0000};
      default:   w_shamt = 5'd0;
    endcase
    w_shifted   = i_rd_data >> w_shamt;
    o_ld_data_c = w_shifted;
    case (i_ld_size)
      SIZE_BYTE: o_ld_data_c = {{24{i_ld_signed & w_shifted[7]}}, w_shifted[7:0]};
      SIZE_HALF: o_ld_data_c = {{16{i_ld_signed & w_shifted[15]}}, w_shifted[15:0]};
      default:   ;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates the external memory bus between instruction fetch and the
// memory stage, alternating grants on a tie.
module bus_arbiter
  import bus_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_request,
  input  logic [BUS_W-1:0]  fetch_address,
  output logic [BUS_W-1:0]  fetch_data,
  output logic              fetch_ready,
  input  logic              data_load,
  input  logic              data_store,
  input  logic [BUS_W-1:0]  data_address,
  input  logic [1:0]        data_size,
  input  logic              data_signed,
  input  logic [BUS_W-1:0]  data_store_data,
  output logic [BUS_W-1:0]  data_load_data,
  output logic              data_ready,
  output logic              ext_valid,
  output logic              ext_write,
  output logic [BUS_W-1:0]  ext_address,
  output logic [BUS_W-1:0]  ext_write_data,
  output logic [STRB_W-1:0] ext_write_strobe,
  input  logic              ext_ready,
  input  logic [BUS_W-1:0]  ext_read_data
);

  localparam logic [BUS_W-1:0] WORD_MASK = BUS_W'(32'hFFFF_FFFC);

  state_t              r_state;
  state_t              w_next_state;
  grant_t              r_last_grant;
  logic                r_ext_valid;
  logic                r_ext_write;
  logic [BUS_W-1:0]    r_ext_address;
  logic [BUS_W-1:0]    r_ext_write_data;
  logic [STRB_W-1:0]   r_ext_write_strobe;
  logic [BUS_W-1:0]    r_fetch_data;
  logic                r_fetch_ready;
  logic [BUS_W-1:0]    r_data_load_data;
  logic                r_data_ready;
  logic [1:0]          r_size;
  logic [1:0]          r_addr_lo;
  logic                r_signed;

  logic                w_fetch_req;
  logic                w_data_req;
  logic                w_grant_fetch;
  logic                w_grant_data;
  logic                w_done;
  logic [BUS_W-1:0]    w_st_data;
  logic [STRB_W-1:0]   w_st_strobe;
  logic [BUS_W-1:0]    w_ld_data;

  bus_lane_align u_align (
    .i_st_size     (data_size),
    .i_st_addr_lo  (data_address[1:0]),
    .i_st_data     (data_store_data),
    .o_st_data_c   (w_st_data),
    .o_st_strobe_c (w_st_strobe),
    .i_ld_size     (r_size),
    .i_ld_addr_lo  (r_addr_lo),
    .i_ld_signed   (r_signed),
    .i_rd_data     (ext_read_data),
    .o_ld_data_c   (w_ld_data)
  );

  // A requester whose ready pulse is out still shows its old request.
  assign w_fetch_req = fetch_request & ~r_fetch_ready;
  assign w_data_req  = (data_load | data_store) & ~r_data_ready;

  always_comb begin
    w_next_state  = r_state;
    w_grant_fetch = 1'b0;
    w_grant_data  = 1'b0;
    w_done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_data_req && (!w_fetch_req || r_last_grant == GRANT_FETCH)) begin
          w_next_state = DATA;
          w_grant_data = 1'b1;
        end else if (w_fetch_req) begin
          w_next_state  = FETCH;
          w_grant_fetch = 1'b1;
        end
      end
      FETCH, DATA: begin
        if (ext_ready) begin
          w_next_state = IDLE;
          w_done       = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state            <= IDLE;
      r_last_grant       <= GRANT_FETCH;
      r_ext_valid        <= 1'b0;
      r_ext_write        <= 1'b0;
      r_ext_address      <= '0;
      r_ext_write_data   <= '0;
      r_ext_write_strobe <= '0;
      r_fetch_data       <= '0;
      r_fetch_ready      <= 1'b0;
      r_data_load_data   <= '0;
      r_data_ready       <= 1'b0;
      r_size             <= SIZE_WORD;
      r_addr_lo          <= 2'b00;
      r_signed           <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_fetch_ready <= 1'b0;
      r_data_ready  <= 1'b0;
      if (w_grant_fetch) begin
        r_ext_valid        <= 1'b1;
        r_ext_write        <= 1'b0;
        r_ext_address      <= fetch_address & WORD_MASK;
        r_ext_write_data   <= '0;
        r_ext_write_strobe <= '0;
      end
      if (w_grant_data) begin
        r_ext_valid        <= 1'b1;
        r_ext_write        <= data_store;
        r_ext_address      <= data_address & WORD_MASK;
        r_ext_write_data   <= w_st_data;
        r_ext_write_strobe <= data_store ? w_st_strobe : STRB_W'(0);
        r_size             <= data_size;
        r_addr_lo          <= data_address[1:0];
        r_signed           <= data_signed;
      end
      // Completion: capture the response and flip the tie-break owner.
      if (w_done) begin
        r_ext_valid <= 1'b0;
        if (r_state == FETCH) begin
          r_fetch_data  <= ext_read_data;
          r_fetch_ready <= 1'b1;
          r_last_grant  <= GRANT_FETCH;
        end else begin
          if (!r_ext_write) r_data_load_data <= w_ld_data;
          r_data_ready <= 1'b1;
          r_last_grant <= GRANT_DATA;
        end
      end
    end
  end

  assign fetch_data       = r_fetch_data;
  assign fetch_ready      = r_fetch_ready;
  assign data_load_data   = r_data_load_data;
  assign data_ready       = r_data_ready;
  assign ext_valid        = r_ext_valid;
  assign ext_write        = r_ext_write;
  assign ext_address      = r_ext_address;
  assign ext_write_data   = r_ext_write_data;
  assign ext_write_strobe = r_ext_write_strobe;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: the bench plays both pipeline requesters
// and the bus slave, with hand-computed expected values.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_request;
  logic [31:0] fetch_address;
  logic [31:0] fetch_data;
  logic        fetch_ready;
  logic        data_load;
  logic        data_store;
  logic [31:0] data_address;
  logic [1:0]  data_size;
  logic        data_signed;
  logic [31:0] data_store_data;
  logic [31:0] data_load_data;
  logic        data_ready;
  logic        ext_valid;
  logic        ext_write;
  logic [31:0] ext_address;
  logic [31:0] ext_write_data;
  logic [3:0]  ext_write_strobe;
  logic        ext_ready;
  logic [31:0] ext_read_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .fetch_request    (fetch_request),
    .fetch_address    (fetch_address),
    .fetch_data       (fetch_data),
    .fetch_ready      (fetch_ready),
    .data_load        (data_load),
    .data_store       (data_store),
    .data_address     (data_address),
    .data_size        (data_size),
    .data_signed      (data_signed),
    .data_store_data  (data_store_data),
    .data_load_data   (data_load_data),
    .data_ready       (data_ready),
    .ext_valid        (ext_valid),
    .ext_write        (ext_write),
    .ext_address      (ext_address),
    .ext_write_data   (ext_write_data),
    .ext_write_strobe (ext_write_strobe),
    .ext_ready        (ext_ready),
    .ext_read_data    (ext_read_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; fetch_request = 1'b0; fetch_address = '0;
    data_load = 1'b0; data_store = 1'b0; data_address = '0; data_size = 2'b10;
    data_signed = 1'b0; data_store_data = '0; ext_ready = 1'b0; ext_read_data = '0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    chk("rst_valid",   32'(ext_valid), 32'd0);
    chk("rst_write",   32'(ext_write), 32'd0);
    chk("rst_strobe",  32'(ext_write_strobe), 32'd0);
    chk("rst_addr",    ext_address, 32'd0);
    chk("rst_wdata",   ext_write_data, 32'd0);
    chk("rst_fready",  32'(fetch_ready), 32'd0);
    chk("rst_dready",  32'(data_ready), 32'd0);
    chk("rst_fdata",   fetch_data, 32'd0);
    chk("rst_ldata",   data_load_data, 32'd0);

    // Fetch only, zero-wait slave
    fetch_request = 1'b1; fetch_address = 32'h0000_0104;
    cyc();
    chk("f1_valid",  32'(ext_valid), 32'd1);
    chk("f1_write",  32'(ext_write), 32'd0);
    chk("f1_addr",   ext_address, 32'h0000_0104);
    chk("f1_strobe", 32'(ext_write_strobe), 32'd0);
    ext_ready = 1'b1; ext_read_data = 32'h1234_5678;
    cyc();
    chk("f1_ready",  32'(fetch_ready), 32'd1);
    chk("f1_data",   fetch_data, 32'h1234_5678);
    chk("f1_vdrop",  32'(ext_valid), 32'd0);
    fetch_request = 1'b0; ext_ready = 1'b0; ext_read_data = 32'hDEAD_BEEF;
    cyc();
    chk("f1_pulse",  32'(fetch_ready), 32'd0);
    chk("f1_hold",   fetch_data, 32'h1234_5678);
    chk("f1_idle",   32'(ext_valid), 32'd0);

    // Signed byte load at lane 3
    data_load = 1'b1; data_address = 32'h0000_0203; data_size = 2'b00; data_signed = 1'b1;
    cyc();
    chk("lb_valid",  32'(ext_valid), 32'd1);
    chk("lb_addr",   ext_address, 32'h0000_0200);
    chk("lb_strobe", 32'(ext_write_strobe), 32'd0);
    ext_ready = 1'b1; ext_read_data = 32'h80FF_0000;
    cyc();
    chk("lb_ready",  32'(data_ready), 32'd1);
    chk("lb_data",   data_load_data, 32'hFFFF_FF80);
    data_load = 1'b0; ext_ready = 1'b0;
    cyc();
    chk("lb_pulse",  32'(data_ready), 32'd0);
    // Same access, unsigned
    data_load = 1'b1; data_signed = 1'b0;
    cyc();
    ext_ready = 1'b1; ext_read_data = 32'h80FF_0000;
    cyc();
    chk("lbu_data",  data_load_data, 32'h0000_0080);
    data_load = 1'b0; ext_ready = 1'b0;
    cyc();

    // Half store at offset 2
    data_store = 1'b1; data_address = 32'h0000_0012; data_size = 2'b01;
    data_store_data = 32'h0000_ABCD;
    cyc();
    chk("sh_write",  32'(ext_write), 32'd1);
    chk("sh_addr",   ext_address, 32'h0000_0010);
    chk("sh_wdata",  ext_write_data, 32'hABCD_ABCD);
    chk("sh_strobe", 32'(ext_write_strobe), 32'h0000_000C);
    ext_ready = 1'b1;
    cyc();
    chk("sh_ready",  32'(data_ready), 32'd1);
    data_store = 1'b0; ext_ready = 1'b0;
    cyc();

    // Tie straight out of reset: data wins, fetch follows in the data_ready cycle
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    fetch_request = 1'b1; fetch_address = 32'h0000_0200;
    data_load = 1'b1; data_address = 32'h0000_0300; data_size = 2'b10; data_signed = 1'b0;
    cyc();
    chk("t1_addr",   ext_address, 32'h0000_0300);
    chk("t1_write",  32'(ext_write), 32'd0);
    ext_ready = 1'b1; ext_read_data = 32'hCAFE_F00D;
    cyc();
    chk("t1_dready", 32'(data_ready), 32'd1);
    chk("t1_ldata",  data_load_data, 32'hCAFE_F00D);
    chk("t1_fwait",  32'(fetch_ready), 32'd0);
    data_load = 1'b0; ext_ready = 1'b0;
    cyc();
    chk("t1_fvalid", 32'(ext_valid), 32'd1);
    chk("t1_faddr",  ext_address, 32'h0000_0200);
    ext_ready = 1'b1; ext_read_data = 32'h1357_9BDF;
    cyc();
    chk("t1_fready", 32'(fetch_ready), 32'd1);
    chk("t1_fdata",  fetch_data, 32'h1357_9BDF);
    fetch_request = 1'b0; ext_ready = 1'b0;
    cyc();
    // Lone word load, then a tie: fetch must win now
    data_load = 1'b1; data_address = 32'h0000_0040; data_size = 2'b11;
    cyc();
    ext_ready = 1'b1; ext_read_data = 32'h0BAD_F00D;
    cyc();
    chk("w11_data",  data_load_data, 32'h0BAD_F00D);
    data_load = 1'b0; ext_ready = 1'b0;
    cyc();
    fetch_request = 1'b1; fetch_address = 32'h0000_0503;
    data_load = 1'b1; data_address = 32'h0000_0600; data_size = 2'b10;
    cyc();
    chk("t2_faddr",  ext_address, 32'h0000_0500);
    ext_ready = 1'b1; ext_read_data = 32'h2468_ACE0;
    cyc();
    chk("t2_fready", 32'(fetch_ready), 32'd1);
    chk("t2_fdata",  fetch_data, 32'h2468_ACE0);
    fetch_request = 1'b0; ext_ready = 1'b0;
    cyc();
    chk("t2_daddr",  ext_address, 32'h0000_0600);
    chk("t2_dvalid", 32'(ext_valid), 32'd1);
    ext_ready = 1'b1; ext_read_data = 32'h0F0F_0F0F;
    cyc();
    chk("t2_dready", 32'(data_ready), 32'd1);
    data_load = 1'b0; ext_ready = 1'b0;
    cyc();

    // Byte store with a 3-cycle wait from the slave
    data_store = 1'b1; data_address = 32'h0000_0021; data_size = 2'b00;
    data_store_data = 32'h1234_565A;
    cyc();
    chk("ws_wdata",  ext_write_data, 32'h5A5A_5A5A);
    chk("ws_strobe", 32'(ext_write_strobe), 32'h0000_0002);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("ws_valid",  32'(ext_valid), 32'd1);
      chk("ws_addr",   ext_address, 32'h0000_0020);
      chk("ws_stable", ext_write_data, 32'h5A5A_5A5A);
      chk("ws_sstrb",  32'(ext_write_strobe), 32'h0000_0002);
      chk("ws_noready", 32'(data_ready), 32'd0);
    end
    ext_ready = 1'b1;
    cyc();
    chk("ws_ready",  32'(data_ready), 32'd1);
    chk("ws_vdrop",  32'(ext_valid), 32'd0);
    data_store = 1'b0; ext_ready = 1'b0;
    cyc();

    // Reset while DATA is waiting on the slave
    data_load = 1'b1; data_address = 32'h0000_0080; data_size = 2'b10;
    cyc();
    chk("rm_valid",  32'(ext_valid), 32'd1);
    cyc();
    reset = 1'b1;
    cyc();
    chk("rm_valid0", 32'(ext_valid), 32'd0);
    chk("rm_addr0",  ext_address, 32'd0);
    chk("rm_wdata0", ext_write_data, 32'd0);
    chk("rm_fdata0", fetch_data, 32'd0);
    chk("rm_ldata0", data_load_data, 32'd0);
    chk("rm_dready", 32'(data_ready), 32'd0);
    reset = 1'b0; data_load = 1'b0; ext_ready = 1'b1; ext_read_data = 32'h7777_7777;
    cyc();
    chk("rm_noready", 32'(data_ready), 32'd0);
    chk("rm_idle",    32'(ext_valid), 32'd0);
    chk("rm_ignore",  data_load_data, 32'd0);
    ext_ready = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-port arbiter that shares the single external memory bus between instruction fetch and the memory stage's load/store path. It serialises the requests, performs byte-lane steering for stores and extraction/extension for loads, and returns one-cycle `*_ready` pulses that fetch and the hazard unit use to release their stalls. It sits between the pipeline (fetch, memory stage) and the external bus slave.

## Interface
- No parameters. Bus width is fixed at 32 bits.
- Clocking: one clock; reset is synchronous and active-high.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `fetch_request` in 1: fetch wants the 32-bit word at `fetch_address`. Held until `fetch_ready`.
- `fetch_address` in 32: instruction address. Bits [1:0] are ignored.
- `fetch_data` out 32: fetched word, valid while `fetch_ready`.
- `fetch_ready` out 1: one-cycle completion pulse for fetch.
- `data_load` in 1: load request from the memory stage.
- `data_store` in 1: store request from the memory stage. Never asserted together with `data_load`.
- `data_address` in 32: load/store byte address.
- `data_size` in 2: access size. 00 = byte, 01 = half, 10 = word, 11 is treated as word.
- `data_signed` in 1: sign-extend the load result.
- `data_store_data` in 32: store data, right-aligned.
- `data_load_data` out 32: extended load result, valid while `data_ready`.
- `data_ready` out 1: one-cycle completion pulse for a load or store.
- `ext_valid` out 1: bus request active.
- `ext_write` out 1: 1 = write, 0 = read.
- `ext_address` out 32: word address, with bits [1:0] forced to 0.
- `ext_write_data` out 32: lane-steered store data.
- `ext_write_strobe` out 4: byte enables. 0 on reads.
- `ext_ready` in 1: slave completes the current request in this cycle.
- `ext_read_data` in 32: read word, sampled when `ext_ready`.

## Operation
- FSM states:
  - IDLE: no bus transaction in progress.
  - FETCH: instruction fetch in progress on the bus.
  - DATA: load or store in progress on the bus.
- Transitions out of IDLE:
  - A data request present, and either no fetch request or `last_grant` = FETCH → DATA.
  - Otherwise, a fetch request present → FETCH.
  - Otherwise, stay in IDLE.
- Tie-break: when both requests are present, the requester not granted last wins. `last_grant` resets to FETCH, so data wins the first tie.
- On the IDLE→DATA or IDLE→FETCH transition, the request is latched into registers and drives `ext_*` from the next cycle:
  - address, write flag, strobe and write data
  - for data requests also size, `address[1:0]` and signed flag
- In FETCH or DATA:
  - `ext_*` outputs are held constant until `ext_ready`.
  - Requester inputs are not re-sampled during this time.
- On `ext_ready` in FETCH or DATA:
  - register the (formatted) read data
  - pulse the matching `*_ready` in the next cycle
  - update `last_grant`
  - drop `ext_valid` and return to IDLE
- In the cycle a requester's `*_ready` is high, IDLE ignores that requester's request, because it is still asserted from the completed access. The other requester may be granted in that cycle.
- A transaction, once granted, always completes. Withdrawing the request mid-transaction does not abort it, and the `*_ready` pulse is still produced.
- Store lane steering (`a` = `address[1:0]`):
  - Byte: data = `{4{d[7:0]}}`, strobe = `4'b0001 << a`.
  - Half: data = `{2{d[15:0]}}`, strobe = `4'b0011 << {a[1],1'b0}`.
  - Word/11: data = `d`, strobe = `4'b1111`.
- Load extraction:
  - Shift `ext_read_data` right by `8*a` for byte, `16*a[1]` for half, 0 for word.
  - Then zero- or sign-extend from bit 7 or bit 15 according to `data_signed`.
- Misalignment is not checked here; it is filtered upstream. Low address bits beyond the access size are ignored.
- `data_load_data` and `fetch_data` hold their last value outside ready pulses.

## Timing
- Reset values:
  - state = IDLE, `last_grant` = FETCH
  - `ext_valid`, `ext_write`, `ext_write_strobe`, `fetch_ready`, `data_ready` = 0
  - `ext_address`, `ext_write_data`, `fetch_data`, `data_load_data` = 0
- Minimum latency, with request sampled in IDLE at cycle N:
  - `ext_valid` high at N+1.
  - If `ext_ready` is high at N+1, `*_ready` and data are valid at N+2.
  - Each wait cycle of the slave adds one cycle.
- The same requester can start its next access at N+3 at the earliest. The other requester can start at N+2.
- Reset asserted mid-transaction: the next cycle is IDLE with all outputs at reset values, and no `*_ready` is produced. The slave is reset by the same signal.
- `ext_ready` while IDLE is ignored.

## Structure
- Package `bus_pkg` holds:
  - state enum (IDLE, FETCH, DATA)
  - size constants (SIZE_BYTE = 00, SIZE_HALF = 01, SIZE_WORD = 10)
  - grant enum
- Natural sub-module: `bus_lane_align`, purely combinational. It holds store steering/strobe generation and load extraction/extension, and is instantiated once.

## Test plan
- Fetch only, addr 0x0000_0104, slave responds in the same cycle with 0x1234_5678 → `ext_address` = 0x104, `fetch_ready` at N+2 with `fetch_data` = 0x1234_5678.
- Signed byte load, addr 0x0000_0203, read word 0x80FF_0000 → `data_load_data` = 0xFFFF_FF80. Same access unsigned → 0x0000_0080.
- Half store 0x0000_ABCD at addr 0x0000_0012 → `ext_write_data` = 0xABCD_ABCD, strobe = 4'b1100, `ext_write` = 1.
- Fetch and data requested in the same cycle out of reset → DATA granted first. Fetch is granted at the cycle of `data_ready` and completes next. Then a second tie → FETCH granted.
- Slave holds `ext_ready` low for 3 cycles → `ext_*` outputs stay stable across those cycles, and `data_ready` arrives 3 cycles later than in the zero-wait case.
- `reset` asserted while in DATA waiting on the slave → IDLE next cycle, all outputs at reset values, no `data_ready` pulse.
